dcdata_arb: RTL
===============

# dcdata_arb

Port controller and arbiter for the 1024-word, byte-writable data-cache array (`dcdata`). It shares the array's single address path between three requesters: load reads, byte-masked stores, and line reloads from the memory side. Stores are posted into a small store queue so loads are not blocked. The block sits between the LSU/reload logic and `dcdata` and guarantees the array never sees a read and a write in the same cycle, so it works with both the inferred and the RAM-macro array builds.

## Interface
- `LINE_WORDS`, default 4: words per reload burst; power of 2, range 2..16.
- `SQ_DEPTH`, default 2: store-queue entries, range 1..4.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `ld_req` in 1: load request.
- `ld_adr` in 10: load word address.
- `ld_rdy` out 1: load accepted this cycle (when `ld_req`=1).
- `ld_vld` out 1: load data valid.
- `ld_dat` out 32: load data.
- `st_req` in 1: store request.
- `st_adr` in 10, `st_be` in 4, `st_dat` in 32: store address, byte enables, data.
- `st_rdy` out 1: store-queue space available.
- `rl_req` in 1: reload request, held until accepted.
- `rl_adr` in 10: reload base address; low log2(`LINE_WORDS`) bits are ignored (treated as 0).
- `rl_rdy` out 1: reload accepted this cycle.
- `rl_dat_vld` in 1: reload beat valid.
- `rl_dat` in 32: reload beat data.
- `rl_done` out 1: one-cycle pulse, line fill complete.
- `ram_rd_adr` out 10: to `dcdata` `rd_adr`.
- `ram_rd_dat` in 32: from `dcdata` `rd_dat`.
- `ram_wr_en` out 4: to `dcdata` `wr_en`.
- `ram_wr_adr` out 10: to `dcdata` `wr_adr`.
- `ram_wr_dat` out 32: to `dcdata` `wr_dat`.

## Operation
- **State machine:** IDLE and FILL.
- **Store queue:** FIFO of {adr, be, dat}, depth `SQ_DEPTH`.
  - `st_rdy` = count < `SQ_DEPTH`, from registered state. It is 0 when full, even in a cycle that drains the queue.
  - Enqueue on `st_req & st_rdy` in any state.
- **IDLE arbitration per cycle**, highest priority first. Exactly one action per cycle.
  1. `rl_req` and queue empty: `rl_rdy`=1. Latch the aligned base, clear the beat counter, go to FILL. `ld_rdy`=0.
  2. `rl_req` and queue not empty: drain head. `ld_rdy`=0.
  3. Queue full: drain head. `ld_rdy`=0.
  4. `ld_req` and `ld_adr` matches the address of any valid queue entry: drain head. `ld_rdy`=0.
  5. `ld_req`: grant the load. `ld_rdy`=1, `ram_rd_adr`=`ld_adr`, `ram_wr_en`=0.
  6. Queue not empty: drain head.
- **Drain:** `ram_wr_en`=head.be, `ram_wr_adr`=head.adr, `ram_wr_dat`=head.dat; pop the head.
- **Load/store in the same cycle:** a load granted in the same cycle a store is enqueued is older. It reads pre-store data. The hit check covers only entries already in the queue.
- **FILL:**
  - On each `rl_dat_vld`: `ram_wr_en`=4'hF, `ram_wr_adr`=base|beat, `ram_wr_dat`=`rl_dat`; beat increments.
  - On the write of beat `LINE_WORDS`-1: go to IDLE; `rl_done`=1 in the following cycle.
  - `ld_rdy`=0 and no drains throughout FILL; stores may still enqueue.
  - Stores enqueued during FILL drain after it, so they overwrite reloaded bytes.
- `ram_wr_en`=0 whenever no write is performed. `ram_rd_adr` = `ld_adr` in every cycle (don't-care when no load is granted).
- `rl_rdy` is asserted only in IDLE with the queue empty and `rl_req`=1.

## Timing
- **Reset values:** all outputs 0, including `ld_dat`. State IDLE, queue empty, beat counter 0. Asynchronous assert, synchronous release.
- **Reset during FILL:** the fill is abandoned and no `rl_done` is produced. Queue contents are discarded.
- **Load latency:** `ld_vld`=1 exactly one cycle after `ld_req & ld_rdy`. `ld_dat` is `ram_rd_dat` registered in the grant cycle and held until the next grant.
- **Store write latency:** a store is written to the array no earlier than the cycle after enqueue.
- **Reload:** the first beat may arrive in the cycle after `rl_rdy`; gaps between beats are allowed. `rl_dat_vld` outside FILL is ignored.
- **Single-port rule:** a load grant and a nonzero `ram_wr_en` never occur in the same cycle.

## Test plan
- **Load after reset:** preload array[5]=0xA5A5A5A5; `ld_req`, adr 5 in cycle 0 → `ld_rdy`=1 in cycle 0; `ld_vld`=1 with `ld_dat`=0xA5A5A5A5 in cycle 1.
- **Store then dependent load:** store adr 9, be 4'b0011, dat 0x1234BEEF over 0xFFFFFFFF; next cycle `ld_req` adr 9 → `ld_rdy`=0 for one cycle (drain); load then returns 0xFFFFBEEF.
- **Queue full:** 3 back-to-back stores with `SQ_DEPTH`=2 while `ld_req` is held to a non-matching address → `st_rdy`=0 when count=2; the forced drain steals one cycle from loads; all stores reach the array in order.
- **Reload with pending store:** 1 store queued, `rl_req` base 0x40 → store drains first, then `rl_rdy`; 4 beats with one idle gap → writes 0x40..0x43, `rl_done` one cycle after the last beat; loads stalled throughout.
- **Store during FILL:** store to 0x41 accepted mid-fill → after `rl_done`, array[0x41] holds the store bytes merged over the reload data.
- **Reset mid-FILL after 2 beats:** all outputs 0, no `rl_done`; a new reload then completes normally.

Source files
------------

// File: rtl/dcdata_arb.sv
// Port controller for the single-address-path dcdata array: arbitrates load reads,
// posted byte-masked stores and line reloads so the array never reads and writes together.
module dcdata_arb #(
   parameter int LINE_WORDS = 4,
   parameter int SQ_DEPTH   = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ld_req,
   input  logic [9:0]  ld_adr,
   output logic        ld_rdy,
   output logic        ld_vld,
   output logic [31:0] ld_dat,
   input  logic        st_req,
   input  logic [9:0]  st_adr,
   input  logic [3:0]  st_be,
   input  logic [31:0] st_dat,
   output logic        st_rdy,
   input  logic        rl_req,
   input  logic [9:0]  rl_adr,
   output logic        rl_rdy,
   input  logic        rl_dat_vld,
   input  logic [31:0] rl_dat,
   output logic        rl_done,
   output logic [9:0]  ram_rd_adr,
   input  logic [31:0] ram_rd_dat,
   output logic [3:0]  ram_wr_en,
   output logic [9:0]  ram_wr_adr,
   output logic [31:0] ram_wr_dat
);
   // state | meaning
   // IDLE  | arbitrate reload accept, store drain and load grant
   // FILL  | write reload beats; loads and drains held off
   typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

   localparam int BW = $clog2(LINE_WORDS);
   localparam int CW = 3;

   state_t        r_state, w_state_nxt;
   logic [CW-1:0] r_sq_cnt;
   logic [9:0]    r_sq_adr [SQ_DEPTH];
   logic [3:0]    r_sq_be  [SQ_DEPTH];
   logic [31:0]   r_sq_dat [SQ_DEPTH];
   logic [9:0]    r_rl_base;
   logic [BW-1:0] r_beat;
   logic          r_ld_vld;
   logic [31:0]   r_ld_dat;
   logic          r_rl_done;

   logic          w_empty, w_full, w_hit, w_push, w_pop, w_grant;
   logic          w_accept_rl, w_beat_wr, w_last_beat;
   logic [CW-1:0] w_wr_idx;

   always_comb begin
      w_empty     = (r_sq_cnt == '0);
      w_full      = (r_sq_cnt == CW'(SQ_DEPTH));
      w_last_beat = (r_beat == BW'(LINE_WORDS - 1));
      w_hit       = 1'b0;
      for (int i = 0; i < SQ_DEPTH; i++) begin
         if ((CW'(i) < r_sq_cnt) && (r_sq_adr[i] == ld_adr)) w_hit = 1'b1;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_grant     = 1'b0;
      w_accept_rl = 1'b0;
      w_beat_wr   = 1'b0;
      if (rst_n) begin
         case (r_state)
            IDLE: begin
               if (rl_req && w_empty) begin
                  w_accept_rl = 1'b1;
                  w_state_nxt = FILL;
               end else if (rl_req || w_full || (ld_req && w_hit)) begin
                  w_pop = 1'b1;
               end else if (ld_req) begin
                  w_grant = 1'b1;
               end else if (!w_empty) begin
                  w_pop = 1'b1;
               end
            end
            FILL: begin
               if (rl_dat_vld) begin
                  w_beat_wr = 1'b1;
                  if (w_last_beat) w_state_nxt = IDLE;
               end
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   // st_rdy comes from registered occupancy only, so a draining full queue still refuses
   always_comb begin
      st_rdy     = rst_n & ~w_full;
      w_push     = st_req & st_rdy;
      w_wr_idx   = r_sq_cnt - CW'(w_pop);
      ld_rdy     = w_grant;
      rl_rdy     = w_accept_rl;
      ram_rd_adr = rst_n ? ld_adr : 10'd0;
      ram_wr_en  = 4'd0;
      ram_wr_adr = 10'd0;
      ram_wr_dat = 32'd0;
      if (w_pop) begin
         ram_wr_en  = r_sq_be[0];
         ram_wr_adr = r_sq_adr[0];
         ram_wr_dat = r_sq_dat[0];
      end else if (w_beat_wr) begin
         ram_wr_en  = 4'hF;
         ram_wr_adr = r_rl_base | 10'(r_beat);
         ram_wr_dat = rl_dat;
      end
   end

   assign ld_vld  = r_ld_vld;
   assign ld_dat  = r_ld_dat;
   assign rl_done = r_rl_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_rl_base <= '0;
         r_beat    <= '0;
         r_ld_vld  <= 1'b0;
         r_ld_dat  <= '0;
         r_rl_done <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_ld_vld  <= w_grant;
         r_rl_done <= w_beat_wr & w_last_beat;
         if (w_grant) r_ld_dat <= ram_rd_dat;
         if (w_accept_rl) begin
            r_rl_base <= rl_adr & ~10'(LINE_WORDS - 1);
            r_beat    <= '0;
         end else if (w_beat_wr) begin
            r_beat <= r_beat + BW'(1);
         end
      end
   end

   // Shift-register queue: entry 0 is always the head; a push lands after the survivors
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sq_cnt <= '0;
         for (int i = 0; i < SQ_DEPTH; i++) begin
            r_sq_adr[i] <= '0;
            r_sq_be[i]  <= '0;
            r_sq_dat[i] <= '0;
         end
      end else begin
         r_sq_cnt <= r_sq_cnt + CW'(w_push) - CW'(w_pop);
         if (w_pop) begin
            for (int i = 0; i < SQ_DEPTH - 1; i++) begin
               r_sq_adr[i] <= r_sq_adr[i+1];
               r_sq_be[i]  <= r_sq_be[i+1];
               r_sq_dat[i] <= r_sq_dat[i+1];
            end
         end
         for (int i = 0; i < SQ_DEPTH; i++) begin
            if (w_push && (CW'(i) == w_wr_idx)) begin
               r_sq_adr[i] <= st_adr;
               r_sq_be[i]  <= st_be;
               r_sq_dat[i] <= st_dat;
            end
         end
      end
   end
endmodule
